// File: rtl/regfile_sequencer.sv
// Moore instruction sequencer for the 8 x 16-bit register file datapath.
// Define REGSEQ_ILLEGAL_TRAP_EN to trap illegal opcodes in a HALT state (err=1).
module regfile_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic [15:0]       instr,
    output logic              w,
    output logic              err,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        aluop,
    output logic [DATA_W-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
`ifdef REGSEQ_ILLEGAL_TRAP_EN
        S_WR_REG,
        S_HALT
`else
        S_WR_REG
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // Datapath fields ride directly on the latched instruction.
    assign shift  = ir_q[4:3];
    assign aluop  = op;
    assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && s) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)      state_d = S_WR_IMM;
                else if (is_mov_reg) state_d = S_GET_B;
                else if (is_alu)     state_d = S_GET_A;
`ifdef REGSEQ_ILLEGAL_TRAP_EN
                else                 state_d = S_HALT;
`else
                else                 state_d = S_WAIT;
`endif
            end
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
`ifdef REGSEQ_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    // Outputs are a pure function of state and IR, so reset kills write at once.
    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_WR_IMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                loadc = !is_cmp;
                loads = is_cmp;
                asel  = is_mov_reg || is_mvn;
            end
            S_WR_REG: begin
                writenum = rd;
                vsel     = 2'b00;
                write    = 1'b1;
            end
`ifdef REGSEQ_ILLEGAL_TRAP_EN
            S_HALT: err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
